// File: rtl/ogpu_pkg.sv
// Shared types and defaults for the OpenGPU quad-store path to HPS software.
package ogpu_pkg;

  localparam int OGPU_QUAD_FIFO_DEPTH = 8;
  localparam int OGPU_ACK_SYNC_STAGES = 2;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } ogpu_quad_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    ACK_LOW = 2'b10
  } quad_store_state_t;

endpackage

// File: rtl/ogpu_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible on
// pop_data whenever empty is low. DEPTH must be a power of two.
module ogpu_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pushes into a full FIFO and pops from an empty one are dropped here, so
  // callers may present requests unqualified.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone decide
  // which entries are valid, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ogpu_quad_store_tx.sv
// FPGA-side initiator of the quad-store PIO handshake: buffers raster quads and
// hands each one to HPS software over a four-phase req/ack exchange.
module ogpu_quad_store_tx
  import ogpu_pkg::*;
#(
  parameter int FIFO_DEPTH      = OGPU_QUAD_FIFO_DEPTH,
  parameter int ACK_SYNC_STAGES = OGPU_ACK_SYNC_STAGES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          quad_valid,
  input  logic [63:0]                   quad_data,
  output logic                          quad_ready,
  output logic                          store_req,
  output logic [31:0]                   store_data_high,
  output logic [31:0]                   store_data_low,
  input  logic                          store_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic [31:0]                   quads_sent
);

  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;
  ogpu_quad_t                  fifo_head;
  ogpu_quad_t                  data_q;
  quad_store_state_t           state_q;
  quad_store_state_t           state_d;
  logic                        req_q;
  logic                        sent_inc;
  logic [31:0]                 sent_cnt;
  logic [ACK_SYNC_STAGES-1:0]  ack_sync;
  logic                        ack_s;

  // Ready depends only on FIFO occupancy, never on quad_valid.
  assign quad_ready = !fifo_full;

  ogpu_sync_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (quad_valid),
    .push_data (quad_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // store_ack is written by software through the PIO and is asynchronous here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ack_sync <= '0;
    else       ack_sync <= {ack_sync[ACK_SYNC_STAGES-2:0], store_ack};
  end

  assign ack_s = ack_sync[ACK_SYNC_STAGES-1];

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    sent_inc = 1'b0;
    case (state_q)
      IDLE: begin
        // A high ack here is stale or spurious; wait for it to clear.
        if (!fifo_empty && !ack_s) begin
          fifo_pop = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (ack_s) state_d = ACK_LOW;
      end
      ACK_LOW: begin
        if (!ack_s) begin
          sent_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      data_q   <= '0;
      sent_cnt <= '0;
    end else begin
      state_q <= state_d;
      // Registered so the PIO never sees a decode glitch between states.
      req_q   <= (state_d == REQ);
      if (fifo_pop) data_q   <= fifo_head;
      if (sent_inc) sent_cnt <= sent_cnt + 32'd1;
    end
  end

  assign store_req       = req_q;
  assign store_data_high = data_q.hi;
  assign store_data_low  = data_q.lo;
  assign quads_sent      = sent_cnt;
  assign busy            = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_ogpu_quad_store_tx.sv
// Self-checking bench for ogpu_quad_store_tx: table-driven single handshakes,
// directed corner sequences, and a randomised scoreboard run.
module tb_ogpu_quad_store_tx;
  import ogpu_pkg::*;

  localparam int FD  = 8;
  localparam int NS  = 2;
  localparam int LW  = $clog2(FD) + 1;
  localparam int TMO = 500;

  logic          clk = 1'b0;
  logic          reset;
  logic          quad_valid;
  logic [63:0]   quad_data;
  logic          quad_ready;
  logic          store_req;
  logic [31:0]   store_data_high;
  logic [31:0]   store_data_low;
  logic          store_ack;
  logic [LW-1:0] fifo_level;
  logic          busy;
  logic [31:0]   quads_sent;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  ogpu_quad_store_tx #(
    .FIFO_DEPTH      (FD),
    .ACK_SYNC_STAGES (NS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .quad_valid      (quad_valid),
    .quad_data       (quad_data),
    .quad_ready      (quad_ready),
    .store_req       (store_req),
    .store_data_high (store_data_high),
    .store_data_low  (store_data_low),
    .store_ack       (store_ack),
    .fifo_level      (fifo_level),
    .busy            (busy),
    .quads_sent      (quads_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard producer side: record every accepted quad.
  always @(posedge clk) begin
    if (!reset && quad_valid && quad_ready) exp_q.push_back(quad_data);
  end

  // Data must hold while req stays high; level can never exceed depth.
  logic        prev_req = 1'b0;
  logic [63:0] prev_data = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_req && store_req)
        check("data_stable", {store_data_high, store_data_low}, prev_data);
      check("level_max", 64'(fifo_level <= LW'(FD)), 64'd1);
    end
    prev_req  = store_req;
    prev_data = {store_data_high, store_data_low};
  end

  task automatic wait_req(input logic lvl);
    int n = 0;
    while (store_req !== lvl && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", 64'(store_req), 64'(lvl));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 64'(busy), 64'd0);
  endtask

  // Software model: poll req, read, ack after dly cycles, poll !req, drop ack.
  task automatic sw_handshake(input int dly);
    logic [63:0] got;
    logic [63:0] exp;
    wait_req(1'b1);
    got = {store_data_high, store_data_low};
    check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("sb_data", got, exp);
    end
    repeat (dly) @(negedge clk);
    store_ack = 1'b1;
    wait_req(1'b0);
    store_ack = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_quad(input logic [63:0] d);
    int n = 0;
    quad_valid = 1'b1;
    quad_data  = d;
    while (!quad_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("push_wait", 64'(quad_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    quad_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    store_ack  = 1'b0;
    quad_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [63:0] quad;
    int          ack_delay;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] exp_cnt;

    vecs[0] = '{64'h1122334455667788, 5, 32'h11223344, 32'h55667788};
    vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[2] = '{64'h0000000000000000, 2, 32'h00000000, 32'h00000000};
    vecs[3] = '{64'hA5A5A5A55A5A5A5A, 1, 32'hA5A5A5A5, 32'h5A5A5A5A};

    reset      = 1'b1;
    quad_valid = 1'b0;
    quad_data  = '0;
    store_ack  = 1'b0;
    #1;
    check("rst_req",   64'(store_req), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_ready", 64'(quad_ready), 64'd1);
    check("rst_count", 64'(quads_sent), 64'd0);
    check("rst_data",  {store_data_high, store_data_low}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single handshakes with exact edge timing.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      quad_valid = 1'b1;
      quad_data  = vecs[i].quad;
      check("t_ready", 64'(quad_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      quad_valid = 1'b0;
      check("t_req_early", 64'(store_req), 64'd0);
      @(negedge clk);
      check("t_req_rise", 64'(store_req), 64'd1);
      check("t_hi", 64'(store_data_high), 64'(vecs[i].exp_hi));
      check("t_lo", 64'(store_data_low), 64'(vecs[i].exp_lo));
      check("t_busy", 64'(busy), 64'd1);
      repeat (vecs[i].ack_delay) @(negedge clk);
      store_ack = 1'b1;
      repeat (NS) @(negedge clk);
      check("t_req_hold", 64'(store_req), 64'd1);
      @(negedge clk);
      check("t_req_fall", 64'(store_req), 64'd0);
      check("t_cnt_hold", 64'(quads_sent), 64'(i));
      store_ack = 1'b0;
      repeat (NS) @(negedge clk);
      check("t_cnt_early", 64'(quads_sent), 64'(i));
      @(negedge clk);
      check("t_cnt_inc", 64'(quads_sent), 64'(i + 1));
      check("t_busy_end", 64'(busy), 64'd0);
      check("t_sb_size", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) check("t_sb", exp_q.pop_front(), vecs[i].quad);
    end

    // Burst of 12 with software stalled: 9 accepted, then FIFO full.
    do_reset();
    for (int i = 0; i < 9; i++) push_quad(64'h1000_0000_0000_0000 + 64'(i));
    check("burst_ready", 64'(quad_ready), 64'd0);
    check("burst_level", 64'(fifo_level), 64'(FD));
    check("burst_req",   64'(store_req), 64'd1);
    fork
      begin
        for (int i = 9; i < 12; i++) push_quad(64'h1000_0000_0000_0000 + 64'(i));
      end
      begin
        for (int i = 0; i < 12; i++) sw_handshake(1);
      end
    join
    wait_idle();
    check("burst_count", 64'(quads_sent), 64'd12);
    check("burst_sb_empty", 64'(exp_q.size()), 64'd0);

    // Stale ack held before any quad: no request until ack_s clears.
    do_reset();
    store_ack = 1'b1;
    repeat (4) @(negedge clk);
    push_quad(64'hDEAD_BEEF_0BAD_F00D);
    repeat (3) @(negedge clk);
    check("stale_req",   64'(store_req), 64'd0);
    check("stale_level", 64'(fifo_level), 64'd1);
    check("stale_busy",  64'(busy), 64'd1);
    store_ack = 1'b0;
    repeat (NS) @(negedge clk);
    check("stale_req_wait", 64'(store_req), 64'd0);
    @(negedge clk);
    check("stale_req_rise", 64'(store_req), 64'd1);
    sw_handshake(1);
    wait_idle();
    check("stale_count", 64'(quads_sent), 64'd1);

    // Reset in REQ with three quads buffered.
    do_reset();
    push_quad(64'h0101_0101_0202_0202);
    sw_handshake(2);
    wait_idle();
    check("rr_count_pre", 64'(quads_sent), 64'd1);
    for (int i = 0; i < 4; i++) push_quad(64'h3000_0000_0000_0000 + 64'(i));
    check("rr_req_pre",   64'(store_req), 64'd1);
    check("rr_level_pre", 64'(fifo_level), 64'd3);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("rr_req",   64'(store_req), 64'd0);
    check("rr_level", 64'(fifo_level), 64'd0);
    check("rr_count", 64'(quads_sent), 64'd0);
    check("rr_ready", 64'(quad_ready), 64'd1);
    check("rr_busy",  64'(busy), 64'd0);
    check("rr_data",  {store_data_high, store_data_low}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    push_quad(64'hCAFE_F00D_1234_5678);
    sw_handshake(0);
    wait_idle();
    check("rr_count_post", 64'(quads_sent), 64'd1);

    // Counter wrap from a forced preload.
    do_reset();
    force dut.sent_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.sent_cnt;
    @(negedge clk);
    check("wrap_preload", 64'(quads_sent), 64'hFFFF_FFFE);
    exp_cnt = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      push_quad(64'h7000_0000_0000_0000 + 64'(k));
      sw_handshake(1);
      wait_idle();
      exp_cnt = exp_cnt + 32'd1;
      check("wrap_count", 64'(quads_sent), 64'(exp_cnt));
    end

    // Randomised valid/ack timing over 1000 quads.
    do_reset();
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          push_quad({$urandom, $urandom});
        end
      end
      begin
        for (int i = 0; i < 1000; i++) sw_handshake(int'($urandom_range(0, 4)));
      end
    join
    wait_idle();
    check("rand_count", 64'(quads_sent), 64'd1000);
    check("rand_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
